serializador: RTL and testbench

- Transmit-side counterpart of the deserializer: loads one parallel word from the queue side and emits it one bit per clock on a serial data/write pair.
- Uses the same bit-level framing the deserializer consumes: `write_out` high qualifies each `data_out` bit.
- Sits between the queue output and the serial link, in the 100 kHz clock domain.
- Performs a valid/ack handshake on the parallel side, a stall input on the serial side, and an optional inter-word idle gap.

---
 rtl/serializador.sv | 134 +++++++++++++
 tb/tb_serializador.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: accepts one word over a valid/ack handshake
// and emits it one bit per clock, qualified by write_out, with an optional idle gap.
module serializador #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clock_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  ack_out,
  input  logic                  stall_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  done_out,
  output logic                  status_out
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]        GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [3:0]            gap_cnt;
  logic                  ack_q;
  logic                  accept;
  logic                  last_xfer;
  logic                  out_bit;

  assign out_bit    = LSB_FIRST ? shift_q[0] : shift_q[DATA_WIDTH-1];
  assign shift_next = LSB_FIRST ? {1'b0, shift_q[DATA_WIDTH-1:1]}
                                : {shift_q[DATA_WIDTH-2:0], 1'b0};

  // Leaving SHIFT (no gap) or GAP doubles as the IDLE sampling point, so a
  // source holding valid is accepted without losing a cycle between words.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    state_next = state;
    accept     = 1'b0;
    last_xfer  = 1'b0;
    data_out   = 1'b0;
    write_out  = 1'b0;
    done_out   = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_valid_in) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        data_out  = out_bit;
        write_out = ~stall_in;
        last_xfer = ~stall_in && (bit_cnt == LAST_BIT);
        done_out  = last_xfer;
        if (last_xfer) begin
          if (HAS_GAP) begin
            state_next = GAP;
          end else if (data_valid_in) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (data_valid_in) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign status_out = (state != IDLE);
  assign ack_out    = ack_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the shift register is plain flops, not a memory, so it is cleared
  // on reset along with the counters; a dropped word leaves no residue.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= accept;

      if (accept) begin
        shift_q <= data_in;
        bit_cnt <= '0;
      end else if (state == SHIFT && write_out) begin
        shift_q <= shift_next;
        bit_cnt <= last_xfer ? '0 : bit_cnt + 1'b1;
      end

      if (last_xfer) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador: an MSB-first instance with a one-cycle
// gap and an LSB-first instance with no gap, each with its own bit scoreboard.
`timescale 1ns/1ps
module tb_serializador;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din   [2];
  logic         valid [2];
  logic         stall [2];
  logic         ack   [2];
  logic         dout  [2];
  logic         wr    [2];
  logic         done  [2];
  logic         busy  [2];

  always #5 clk = ~clk;

  serializador #(.DATA_WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(1)) u_msb (
    .clock_100KHz (clk),
    .reset        (rst_n),
    .data_in      (din[0]),
    .data_valid_in(valid[0]),
    .ack_out      (ack[0]),
    .stall_in     (stall[0]),
    .data_out     (dout[0]),
    .write_out    (wr[0]),
    .done_out     (done[0]),
    .status_out   (busy[0])
  );

  serializador #(.DATA_WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u_lsb (
    .clock_100KHz (clk),
    .reset        (rst_n),
    .data_in      (din[1]),
    .data_valid_in(valid[1]),
    .ack_out      (ack[1]),
    .stall_in     (stall[1]),
    .data_out     (dout[1]),
    .write_out    (wr[1]),
    .done_out     (done[1]),
    .status_out   (busy[1])
  );

  typedef struct {
    bit b;
    bit last;
  } sb_t;

  typedef struct {
    int         d;
    logic [7:0] word;
    logic [7:0] pat;   // expected wire order, first bit in pat[7]
  } vec_t;

  sb_t sb0 [$];
  sb_t sb1 [$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_pattern(input int d, input logic [7:0] pat);
    sb_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b    = pat[i];
      e.last = (i == 0);
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  // {ack, write, done, busy} in one cycle
  task automatic cyc_check(input string tag, input int d, input int k, input logic [3:0] exp);
    check($sformatf("%s_c%0d", tag, k), {ack[d], wr[d], done[d], busy[d]}, exp);
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    bit  empty;
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        if (wr[d]) begin
          empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
          if (empty) begin
            check($sformatf("dut%0d_unexpected_write", d), 1, 0);
          end else begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("dut%0d_bit", d), dout[d], e.b);
            check($sformatf("dut%0d_done", d), done[d], e.last);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] word, input logic [7:0] pat);
    bit got;
    push_pattern(d, pat);
    @(posedge clk); #1;
    din[d]   = word;
    valid[d] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack[d];
    end
    check($sformatf("dut%0d_send_ack_%0h", d, word), got, 1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !busy[d];
    end
    check($sformatf("dut%0d_wait_idle", d), idle, 1);
  endtask

  // One word on the MSB instance with a stall mask (bit k = stall in cycle k
  // after the accept edge, bit 0 = stall while idle); len = stalled bit cycles.
  task automatic timed_word(input string tag, input logic [7:0] word, input logic [7:0] pat,
                            input logic [15:0] mask, input int len, input int ncyc);
    int   wr_count;
    logic exp_wr;
    push_pattern(0, pat);
    @(posedge clk); #1;
    din[0]   = word;
    valid[0] = 1'b1;
    stall[0] = mask[0];
    @(posedge clk); #1;
    valid[0] = 1'b0;
    wr_count = 0;
    for (int k = 1; k <= ncyc; k++) begin
      stall[0] = mask[k];
      @(negedge clk);
      exp_wr = (k <= W + len) && !mask[k];
      cyc_check(tag, 0, k, {k == 1, exp_wr, k == W + len, k <= W + 1 + len});
      if (wr[0]) wr_count++;
      @(posedge clk); #1;
    end
    stall[0] = 1'b0;
    check({tag, "_write_pulses"}, wr_count, W);
  endtask

  vec_t vecs [5];
  int   acks;
  bit   got2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 8'b1010_0101};
    vecs[1] = '{1, 8'h01, 8'b1000_0000};
    vecs[2] = '{0, 8'h3C, 8'b0011_1100};
    vecs[3] = '{1, 8'hC3, 8'b1100_0011};
    vecs[4] = '{1, 8'h6E, 8'b0111_0110};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      din[d]   = '0;
      valid[d] = 1'b0;
      stall[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      cyc_check($sformatf("reset_dut%0d", d), d, 0, 4'b0000);
      check($sformatf("reset_dout_dut%0d", d), dout[d], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // table of single words on either instance
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].word, vecs[i].pat);
      wait_idle(vecs[i].d);
    end

    // exact timing of 0xA5, then 0xFF with a 3-cycle stall on bit 4 and stalls in IDLE/GAP
    timed_word("a5_timing", 8'hA5, 8'b1010_0101, 16'h0000, 0, 11);
    timed_word("ff_stall",  8'hFF, 8'b1111_1111, 16'h1071, 3, 14);

    // back-to-back words on the gapless LSB instance with valid held high
    push_pattern(1, 8'b0011_1100);
    push_pattern(1, 8'b1100_0011);
    @(posedge clk); #1;
    din[1]   = 8'h3C;
    valid[1] = 1'b1;
    @(posedge clk); #1;
    acks = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      cyc_check("b2b", 1, k, {k == 1 || k == 9, k <= 16, k == 8 || k == 16, k <= 16});
      if (ack[1]) acks++;
      @(posedge clk); #1;
      if (acks == 1) din[1]   = 8'hC3;
      if (acks >= 2) valid[1] = 1'b0;
    end
    valid[1] = 1'b0;

    // reset in the middle of 0x5A, then a clean 0x81
    push_pattern(0, 8'b0101_1010);
    @(posedge clk); #1;
    din[0]   = 8'h5A;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("midword_reset_dut%0d", d), {ack[d], dout[d], wr[d], done[d], busy[d]}, 5'b00000);
    sb0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cyc_check("post_reset_idle", 0, k, 4'b0000);
    end
    send(0, 8'h81, 8'b1000_0001);
    wait_idle(0);

    // valid pulsed mid-word is ignored; valid held across the gap is taken at its end
    push_pattern(0, 8'b1001_0110);
    push_pattern(0, 8'b0000_1111);
    @(posedge clk); #1;
    din[0]   = 8'h96;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    got2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin
        din[0]   = 8'h0F;
        valid[0] = 1'b1;
      end else if (k == 5) begin
        valid[0] = 1'b0;
      end else if (k >= 6) begin
        valid[0] = !got2;
      end
      @(negedge clk);
      cyc_check("busy_valid", 0, k, {k == 1 || k == 10, k <= 8 || (k >= 10 && k <= 17),
                                     k == 8 || k == 17, k <= 18});
      if (k > 1 && ack[0]) got2 = 1'b1;
      @(posedge clk); #1;
    end
    valid[0] = 1'b0;

    repeat (3) @(posedge clk);
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
